// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the interval-timer sequencer: FSM state encodings
// and the default prescale ratio.
package counter_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_PRESC = 50_000_000;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// Free-running divide-by-PRESC phase counter that advances only while the
// sequencer is running and freezes while it is paused.
module tick_prescaler #(
  parameter int PRESC = 50_000_000,
  parameter int PW    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold,
  input  logic zero,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] count;

  // Any state other than run or hold restarts the phase from zero.
  always_ff @(posedge clk) begin
    if (reset || zero) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end else if (!hold) begin
      count <= '0;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Interval-timer controller: latches preset/direction, loads the attached
// counter, steps it at the prescaled rate and pulses done at the target.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int N     = 4,
  parameter int PRESC = DEFAULT_PRESC,
  parameter int PW    = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic         dir,
  input  logic [N-1:0] preset,
  input  logic [N-1:0] cnt_q,
  output logic         cnt_en,
  output logic         cnt_load,
  output logic         cnt_up,
  output logic         cnt_clr,
  output logic [N-1:0] cnt_d,
  output logic         busy,
  output logic         paused,
  output logic         done
);

  state_t       state;
  logic         dir_r;
  logic [N-1:0] preset_r;
  logic         clr_r;
  logic [N-1:0] target;
  logic         at_target;
  logic         tick;

  assign target    = dir_r ? preset_r : '0;
  assign at_target = (cnt_q == target);

  tick_prescaler #(
    .PRESC(PRESC),
    .PW   (PW)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (state == ST_RUN),
    .hold (state == ST_PAUSE),
    .zero (clear),
    .tick (tick)
  );

  // Clear overrides every state; reaching the target beats a pause request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dir_r    <= 1'b0;
      preset_r <= '0;
      clr_r    <= 1'b0;
    end else begin
      clr_r <= clear;
      if (clear) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              dir_r    <= dir;
              preset_r <= preset;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: state <= ST_RUN;
          ST_RUN: begin
            if (at_target)  state <= ST_DONE;
            else if (pause) state <= ST_PAUSE;
          end
          ST_PAUSE: begin
            if (start) state <= ST_RUN;
          end
          ST_DONE: begin
            if (start) begin
              dir_r    <= dir;
              preset_r <= preset;
              state    <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cnt_load = (state == ST_LOAD);
  assign cnt_up   = dir_r;
  assign cnt_clr  = clr_r;
  assign cnt_d    = (state == ST_LOAD && !dir_r) ? preset_r : '0;
  assign cnt_en   = (state == ST_RUN) && tick && !at_target;
  assign busy     = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_PAUSE);
  assign paused   = (state == ST_PAUSE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural universal counter
// attached; expected timings are hand-derived for N=4, PRESC=4.
module tb_counter_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, pause, clear, dir;
  logic [N-1:0] preset;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic         cnt_en, cnt_load, cnt_up, cnt_clr;
  logic         busy, paused, done;

  int tests    = 0;
  int failures = 0;
  int en_count = 0;

  always #5 clk = ~clk;

  counter_sequencer #(
    .N    (N),
    .PRESC(4),
    .PW   (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .dir     (dir),
    .preset  (preset),
    .cnt_q   (cnt_q),
    .cnt_en  (cnt_en),
    .cnt_load(cnt_load),
    .cnt_up  (cnt_up),
    .cnt_clr (cnt_clr),
    .cnt_d   (cnt_d),
    .busy    (busy),
    .paused  (paused),
    .done    (done)
  );

  // Universal binary counter: clear beats load beats enable.
  always_ff @(posedge clk) begin
    if (reset)         cnt_q <= '0;
    else if (cnt_clr)  cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en)   cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  task automatic checkOutput(input string tag, input int c,
                             input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cycle %0d observed=%0h expected=%0h", tag, c, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic cl,
                               input logic d, input logic [N-1:0] pr);
    start  = s;
    pause  = p;
    clear  = cl;
    dir    = d;
    preset = pr;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    repeat (3) nextCycle;
    checkOutput("rst_en",     0, cnt_en,   0);
    checkOutput("rst_load",   0, cnt_load, 0);
    checkOutput("rst_up",     0, cnt_up,   0);
    checkOutput("rst_clr",    0, cnt_clr,  0);
    checkOutput("rst_d",      0, cnt_d,    0);
    checkOutput("rst_busy",   0, busy,     0);
    checkOutput("rst_paused", 0, paused,   0);
    checkOutput("rst_done",   0, done,     0);
    reset = 1'b0;
    nextCycle;

    $display("[TB] up count, preset 5");
    for (int c = 0; c <= 24; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b1, 4'd5);
      checkOutput("s1_load", c, cnt_load, c == 1);
      checkOutput("s1_en",   c, cnt_en, c == 5 || c == 9 || c == 13 || c == 17 || c == 21);
      checkOutput("s1_done", c, done, c == 23);
      checkOutput("s1_busy", c, busy, c >= 1 && c <= 22);
      if (c == 22) checkOutput("s1_q", c, cnt_q, 5);
      nextCycle;
    end

    $display("[TB] down count, preset 3");
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 4'd3);
      checkOutput("s2_d",    c, cnt_d, (c == 1) ? 3 : 0);
      checkOutput("s2_up",   c, cnt_up, c == 0);
      checkOutput("s2_done", c, done, c == 15);
      if (c >= 2) checkOutput("s2_q", c, cnt_q, 3 - int'(c > 5) - int'(c > 9) - int'(c > 13));
      nextCycle;
    end

    $display("[TB] down count, preset 0");
    for (int c = 0; c <= 5; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("s3_done", c, done, c == 3);
      checkOutput("s3_en",   c, cnt_en, 0);
      checkOutput("s3_busy", c, busy, c == 1 || c == 2);
      nextCycle;
    end

    $display("[TB] pause and resume, up count, preset 2");
    for (int c = 0; c <= 23; c++) begin
      applyStimulus(c == 0 || c == 3 || c == 16, c == 1 || c == 6, 1'b0, 1'b1, 4'd2);
      checkOutput("s4_paused", c, paused, c >= 7 && c <= 16);
      checkOutput("s4_done",   c, done, c == 21);
      checkOutput("s4_en",     c, cnt_en, c == 5 || c == 19);
      checkOutput("s4_busy",   c, busy, c >= 1 && c <= 20);
      if (c == 20) checkOutput("s4_q", c, cnt_q, 2);
      nextCycle;
    end

    $display("[TB] clear during run");
    for (int c = 0; c <= 18; c++) begin
      applyStimulus(c == 0, 1'b0, c == 14, 1'b1, 4'd5);
      checkOutput("s5_clr",  c, cnt_clr, c == 15);
      checkOutput("s5_done", c, done, 0);
      checkOutput("s5_busy", c, busy, c >= 1 && c <= 14);
      checkOutput("s5_en",   c, cnt_en, c == 5 || c == 9 || c == 13);
      if (c == 14 || c == 15) checkOutput("s5_q_hold", c, cnt_q, 3);
      if (c == 16) checkOutput("s5_q_zero", c, cnt_q, 0);
      nextCycle;
    end

    $display("[TB] up count, preset 15, inputs toggled mid-run");
    en_count = 0;
    for (int c = 0; c <= 65; c++) begin
      applyStimulus(c == 0 || c == 30, 1'b0, 1'b0, c < 10, (c < 10) ? 4'd15 : 4'd3);
      checkOutput("s6_done", c, done, c == 63);
      checkOutput("s6_busy", c, busy, c >= 1 && c <= 62);
      checkOutput("s6_up",   c, cnt_up, 1);
      if (c == 62 || c == 63) checkOutput("s6_q", c, cnt_q, 15);
      if (cnt_en) en_count++;
      nextCycle;
    end
    checkOutput("s6_en_total", 65, en_count, 15);

    $display("[TB] synchronous reset mid-run");
    for (int c = 0; c <= 23; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b1, 4'd15);
      reset = (c == 20);
      if (c == 20) checkOutput("s7_busy_pre", c, busy, 1);
      if (c == 21) begin
        checkOutput("s7_en",     c, cnt_en,   0);
        checkOutput("s7_load",   c, cnt_load, 0);
        checkOutput("s7_up",     c, cnt_up,   0);
        checkOutput("s7_clr",    c, cnt_clr,  0);
        checkOutput("s7_d",      c, cnt_d,    0);
        checkOutput("s7_busy",   c, busy,     0);
        checkOutput("s7_paused", c, paused,   0);
        checkOutput("s7_done",   c, done,     0);
        checkOutput("s7_q",      c, cnt_q,    0);
      end
      if (c > 21) checkOutput("s7_idle", c, busy, 0);
      nextCycle;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Controller that drives a universal binary counter (width N, inputs en/load/up/sys_clr/d, outputs q/max_value_tick/min_value_tick) as a programmable interval timer. It latches a preset and a direction, loads the counter, and issues one-cycle count enables at a prescaled rate. It pauses and resumes on command and stops at the target value. When it stops, it pulses `done`. The block sits between the user-control/debounce logic and the counter instance in the timer datapath.

## Interface
- `N`, 4: counter width; must match the attached counter.
- `PRESC`, 50_000_000: clock cycles per count step; legal range is PRESC ≥ 2.
- `PW`, 26: prescaler width; must satisfy 2**PW ≥ PRESC.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle command; begins a run from IDLE or DONE, or resumes from PAUSE.
- `pause` in 1: one-cycle command; suspends counting while in RUN.
- `clear` in 1: one-cycle command; aborts and zeroes the counter from any state.
- `dir` in 1: 1 = count up from 0 to preset; 0 = count down from preset to 0. Sampled only on an accepted start from IDLE or DONE.
- `preset` in N: target (up) or initial value (down). Sampled with `dir`.
- `cnt_q` in N: counter q.
- `cnt_en`, `cnt_load`, `cnt_up`, `cnt_clr` out 1 each: counter control signals.
- `cnt_d` out N: counter load data.
- `busy` out 1: high in LOAD, RUN, and PAUSE.
- `paused` out 1: high in PAUSE.
- `done` out 1: one-cycle pulse when the target is reached.

## Operation
- States and transitions:
  - IDLE: on `start`, latch `dir_r`/`preset_r` and go to LOAD.
  - LOAD: unconditionally go to RUN; prescaler set to 0.
  - RUN: if `cnt_q == target`, go to DONE; else if `pause`, go to PAUSE.
  - PAUSE: on `start`, go to RUN.
  - DONE: go to IDLE. If `start` is asserted in DONE, go to LOAD and latch the new parameters.
- Target value: `preset_r` when up; 0 when down.
- LOAD value: `cnt_d` = 0 when up, `preset_r` when down.
- Outputs are decoded from state:
  - `cnt_load` = 1 in LOAD.
  - `cnt_up` = `dir_r` in all states.
  - `cnt_d` is valid in LOAD and 0 otherwise.
- Prescaler behaviour:
  - Counts 0..PRESC-1 only in RUN.
  - Holds its value in PAUSE, so resume keeps the phase.
  - Cleared in LOAD, IDLE, and DONE.
- `cnt_en` = (state == RUN) & (prescaler == PRESC-1) & (`cnt_q` != target).
- `clear` has highest priority in every state:
  - Next state is IDLE.
  - `cnt_clr` = 1 for exactly the cycle after `clear` is sampled (registered).
  - Prescaler is cleared; `done` is not pulsed.
- Priority and ignored commands:
  - `start` in LOAD or RUN is ignored.
  - `pause` outside RUN is ignored.
  - `start` and `pause` together in RUN: pause wins.
  - `start` and `pause` together in PAUSE: resume.
- Latched parameters: `dir`/`preset` changes while busy have no effect.
- Target reached at load, i.e. up with preset 0 or down with preset 0: DONE on the first RUN cycle, and no `cnt_en` is issued.
- Up with preset 2**N-1: the last step reaches `cnt_q` = 2**N-1. There is no wrap, because `cnt_en` is gated once the target is reached.

## Timing
- Reset values:
  - State = IDLE.
  - `dir_r` = 0, `preset_r` = 0, prescaler = 0.
  - `cnt_en`, `cnt_load`, `cnt_clr`, `cnt_up`, `busy`, `paused`, `done` = 0.
  - `cnt_d` = 0.
- Reset mid-run returns the block to IDLE in the next cycle; the counter has its own reset.
- Cycle numbering: start is sampled in cycle 0. Then:
  - LOAD (`cnt_load` = 1) in cycle 1.
  - `cnt_q` holds the load value and RUN begins in cycle 2.
  - First `cnt_en` in cycle 2+PRESC-1.
- For a run of S steps, with no pause, `done` = 1 in cycle 3 + PRESC·S and IDLE follows in cycle 4 + PRESC·S.
- Each cycle spent in PAUSE delays `done` by exactly one cycle.
- `cnt_clr` asserts one cycle after `clear` is sampled.

## Structure
- Shared package/header holds:
  - State encodings: `ST_IDLE`=3'd0, `ST_LOAD`=3'd1, `ST_RUN`=3'd2, `ST_PAUSE`=3'd3, `ST_DONE`=3'd4.
  - The `PRESC` default.
- One sub-module, `tick_prescaler`:
  - Parameters PRESC and PW.
  - Inputs: `clk`, `reset`, `run`, `hold`, `zero`.
  - Output: `tick` when count == PRESC-1.
- FSM, parameter latches, and output decode live in `counter_sequencer`.

## Test plan
Each scenario uses N=4, PRESC=4, with the real counter attached.
- Up count, preset 5, start in cycle 0:
  - `cnt_load` = 1 in cycle 1.
  - `cnt_en` in cycles 5, 9, 13, 17, 21.
  - `cnt_q` = 5 in cycle 22; `done` = 1 in cycle 23 only.
  - `busy` = 1 over cycles 1–22.
- Down count, preset 3: `cnt_d` = 3 in LOAD, `cnt_q` goes 3→2→1→0, `done` in cycle 15.
- Down count, preset 0: `done` in cycle 3, and `cnt_en` is never asserted.
- Pause/resume, up count, preset 2:
  - Pause sampled in cycle 6 (prescaler = 1 in RUN).
  - Hold for 10 cycles, then start.
  - `done` arrives exactly 10 cycles later than without the pause (cycle 21 vs 11), and `paused` = 1 throughout the hold.
- Clear during RUN at `cnt_q` = 3: `cnt_clr` = 1 for one cycle, next `cnt_q` = 0, state IDLE, no `done` pulse.
- Up count with preset 15:
  - `cnt_q` stops at 15 and `done` occurs in cycle 63.
  - `dir`/`preset` toggled mid-run have no effect.
  - Synchronous reset asserted in a second run returns all outputs to 0 on the next cycle.
